mem_cont_rr: RTL

- Parametrised next-generation memory controller between dataflow load/store ports and a single-port memory with fixed read latency.
- Round-robin arbitration for loads and stores, configurable memory read latency, and one registered response slot per load port.
- Pending-store counter with sticky underflow flag; drives the basic-block "memory empty" handshake.

---
 rtl/mem_cont_rr.sv | 311 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_cont_rr.sv
`default_nettype none
//==============================================================================
// Module   : mem_cont_rr
// Brief    : Memory controller between dataflow load/store ports and a
//            single-port memory with a fixed read latency. Loads and stores
//            are arbitrated independently onto the memory read and write
//            ports. Each load port owns one registered response slot. A
//            pending-store counter drives the basic-block "memory empty"
//            handshake and raises a sticky underflow flag.
// Options  : MEMCONT_RR_EN -- when defined, both arbiters are round-robin
//            (search starts at a per-arbiter pointer). When undefined, they
//            are fixed priority (lowest index wins) and no pointer is built.
// Revision : 1.0 - initial release
//==============================================================================
module mem_cont_rr #(
  parameter int DATA_SIZE    = 32,
  parameter int ADDRESS_SIZE = 32,
  parameter int BB_COUNT     = 1,
  parameter int LOAD_COUNT   = 2,
  parameter int STORE_COUNT  = 2,
  parameter int READ_LATENCY = 1,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  // memory write port
  output logic [DATA_SIZE-1:0]              store_data_out,
  output logic [ADDRESS_SIZE-1:0]           store_addr_out,
  output logic                              store_en,
  // memory read port
  input  logic [DATA_SIZE-1:0]              load_data_in,
  output logic [ADDRESS_SIZE-1:0]           load_addr_out,
  output logic                              load_en,
  // basic-block store accounting
  input  logic [BB_COUNT-1:0]               bb_valid,
  input  logic [BB_COUNT*COUNT_WIDTH-1:0]   bb_st_count,
  output logic [BB_COUNT-1:0]               bb_ready,
  output logic                              empty_valid,
  input  logic                              empty_ready,
  // load address channels
  input  logic [LOAD_COUNT-1:0]             rd_prev_valid,
  input  logic [LOAD_COUNT*ADDRESS_SIZE-1:0] rd_prev_bits,
  output logic [LOAD_COUNT-1:0]             rd_prev_ready,
  // load data channels
  output logic [LOAD_COUNT-1:0]             rd_next_valid,
  output logic [LOAD_COUNT*DATA_SIZE-1:0]   rd_next_bits,
  input  logic [LOAD_COUNT-1:0]             rd_next_ready,
  // store address channels
  input  logic [STORE_COUNT-1:0]            wr_addr_valid,
  input  logic [STORE_COUNT*ADDRESS_SIZE-1:0] wr_addr_bits,
  output logic [STORE_COUNT-1:0]            wr_addr_ready,
  // store data channels
  input  logic [STORE_COUNT-1:0]            wr_data_valid,
  input  logic [STORE_COUNT*DATA_SIZE-1:0]  wr_data_bits,
  output logic [STORE_COUNT-1:0]            wr_data_ready,
  // sticky error
  output logic                              underflow_err
);

  localparam int c_ld_idx_w = (LOAD_COUNT  > 1) ? $clog2(LOAD_COUNT)  : 1;
  localparam int c_st_idx_w = (STORE_COUNT > 1) ? $clog2(STORE_COUNT) : 1;

  // Per-load-port response slot state
  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,   // no request outstanding
    LD_WAIT = 2'd1,   // issued to memory, tag travelling down the pipe
    LD_HOLD = 2'd2    // response registered, waiting for consumer
  } ld_state_t;

  //--------------------------------------------------------------------------
  // Load side signals
  //--------------------------------------------------------------------------
  ld_state_t                   r_ld_state     [LOAD_COUNT];
  logic [LOAD_COUNT-1:0]       r_rd_next_valid;
  logic [DATA_SIZE-1:0]        r_rd_next_bits [LOAD_COUNT];
  logic [LOAD_COUNT-1:0]       r_tag          [READ_LATENCY];

  logic [LOAD_COUNT-1:0]       w_ld_busy;
  logic [LOAD_COUNT-1:0]       w_ld_consume;
  logic [LOAD_COUNT-1:0]       w_ld_elig;
  logic [LOAD_COUNT-1:0]       w_ld_grant;
  logic                        w_ld_found;
  logic [c_ld_idx_w-1:0]       w_ld_start;
  logic [ADDRESS_SIZE-1:0]     w_load_addr;
  logic [LOAD_COUNT-1:0]       w_tag_out;

  //--------------------------------------------------------------------------
  // Store side signals
  //--------------------------------------------------------------------------
  logic [STORE_COUNT-1:0]      w_st_elig;
  logic [STORE_COUNT-1:0]      w_st_grant;
  logic                        w_st_found;
  logic [c_st_idx_w-1:0]       w_st_start;
  logic [ADDRESS_SIZE-1:0]     w_store_addr;
  logic [DATA_SIZE-1:0]        w_store_data;
  logic                        w_store_en;

  logic [COUNT_WIDTH-1:0]      r_st_count;
  logic                        r_underflow;
  logic [COUNT_WIDTH-1:0]      w_st_inc;
  logic                        w_underflow;

  // The consumer-ready handshake on the empty channel carries no state.
  logic                        w_unused_ok;
  assign w_unused_ok = empty_ready;

  //--------------------------------------------------------------------------
  // Per-port load eligibility: idle, or freeing its slot this very cycle
  //--------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < LOAD_COUNT; i++) begin : g_ld_port
      assign w_ld_busy[i]    = (r_ld_state[i] != LD_IDLE);
      assign w_ld_consume[i] = r_rd_next_valid[i] & rd_next_ready[i];
      assign w_ld_elig[i]    = rd_prev_valid[i] & (~w_ld_busy[i] | w_ld_consume[i]);
      assign rd_next_bits[i*DATA_SIZE +: DATA_SIZE] = r_rd_next_bits[i];
    end
  endgenerate

  generate
    for (genvar j = 0; j < STORE_COUNT; j++) begin : g_st_port
      assign w_st_elig[j] = wr_addr_valid[j] & wr_data_valid[j];
    end
  endgenerate

  //--------------------------------------------------------------------------
  // Search start points: rotating pointers, or index 0 for fixed priority
  //--------------------------------------------------------------------------
`ifdef MEMCONT_RR_EN
  logic [c_ld_idx_w-1:0] r_ld_ptr;
  logic [c_st_idx_w-1:0] r_st_ptr;

  assign w_ld_start = r_ld_ptr;
  assign w_st_start = r_st_ptr;

  // Move each pointer to one past the granted index; hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_ptr <= '0;
      r_st_ptr <= '0;
    end else begin
      for (int i = 0; i < LOAD_COUNT; i++) begin
        if (w_ld_grant[i]) begin
          r_ld_ptr <= (i == LOAD_COUNT - 1) ? '0 : c_ld_idx_w'(i + 1);
        end
      end
      for (int j = 0; j < STORE_COUNT; j++) begin
        if (w_st_grant[j]) begin
          r_st_ptr <= (j == STORE_COUNT - 1) ? '0 : c_st_idx_w'(j + 1);
        end
      end
    end
  end
`else
  assign w_ld_start = '0;
  assign w_st_start = '0;
`endif

  //--------------------------------------------------------------------------
  // Load arbiter: first eligible port at or after the start, then wrap
  //--------------------------------------------------------------------------
  always_comb begin
    w_ld_grant  = '0;
    w_ld_found  = 1'b0;
    w_load_addr = '0;
    for (int i = 0; i < LOAD_COUNT; i++) begin
      if (!w_ld_found && w_ld_elig[i] && (i >= int'(w_ld_start))) begin
        w_ld_grant[i] = 1'b1;
        w_ld_found    = 1'b1;
        w_load_addr   = rd_prev_bits[i*ADDRESS_SIZE +: ADDRESS_SIZE];
      end
    end
    for (int i = 0; i < LOAD_COUNT; i++) begin
      if (!w_ld_found && w_ld_elig[i] && (i < int'(w_ld_start))) begin
        w_ld_grant[i] = 1'b1;
        w_ld_found    = 1'b1;
        w_load_addr   = rd_prev_bits[i*ADDRESS_SIZE +: ADDRESS_SIZE];
      end
    end
  end

  assign rd_prev_ready = w_ld_grant;
  assign load_en       = w_ld_found;
  assign load_addr_out = w_load_addr;

  //--------------------------------------------------------------------------
  // Store arbiter: address and data channels are joined per port
  //--------------------------------------------------------------------------
  always_comb begin
    w_st_grant   = '0;
    w_st_found   = 1'b0;
    w_store_addr = '0;
    w_store_data = '0;
    for (int j = 0; j < STORE_COUNT; j++) begin
      if (!w_st_found && w_st_elig[j] && (j >= int'(w_st_start))) begin
        w_st_grant[j] = 1'b1;
        w_st_found    = 1'b1;
        w_store_addr  = wr_addr_bits[j*ADDRESS_SIZE +: ADDRESS_SIZE];
        w_store_data  = wr_data_bits[j*DATA_SIZE +: DATA_SIZE];
      end
    end
    for (int j = 0; j < STORE_COUNT; j++) begin
      if (!w_st_found && w_st_elig[j] && (j < int'(w_st_start))) begin
        w_st_grant[j] = 1'b1;
        w_st_found    = 1'b1;
        w_store_addr  = wr_addr_bits[j*ADDRESS_SIZE +: ADDRESS_SIZE];
        w_store_data  = wr_data_bits[j*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  assign w_store_en     = w_st_found;
  assign store_en       = w_store_en;
  assign store_addr_out = w_store_addr;
  assign store_data_out = w_store_data;
  assign wr_addr_ready  = w_st_grant;
  assign wr_data_ready  = w_st_grant;

  //--------------------------------------------------------------------------
  // Tag pipe: grant vector delayed to line up with returning memory data
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      r_tag[0] <= w_ld_grant;
      for (int s = 1; s < READ_LATENCY; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  assign w_tag_out = r_tag[READ_LATENCY-1];

  //--------------------------------------------------------------------------
  // Load response slots: issue, capture on tag, release on handshake
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LOAD_COUNT; i++) begin
        r_ld_state[i]     <= LD_IDLE;
        r_rd_next_valid[i] <= 1'b0;
        r_rd_next_bits[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LOAD_COUNT; i++) begin
        case (r_ld_state[i])
          LD_IDLE: begin
            if (w_ld_grant[i]) begin
              r_ld_state[i] <= LD_WAIT;
            end
          end
          LD_WAIT: begin
            if (w_tag_out[i]) begin
              r_ld_state[i]      <= LD_HOLD;
              r_rd_next_valid[i] <= 1'b1;
              r_rd_next_bits[i]  <= load_data_in;
            end
          end
          LD_HOLD: begin
            // A consume may coincide with a fresh grant for the same port
            if (w_ld_consume[i]) begin
              r_rd_next_valid[i] <= 1'b0;
              r_ld_state[i]      <= w_ld_grant[i] ? LD_WAIT : LD_IDLE;
            end
          end
          default: begin
            r_ld_state[i]      <= LD_IDLE;
            r_rd_next_valid[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rd_next_valid = r_rd_next_valid;

  //--------------------------------------------------------------------------
  // Sum of store counts announced by basic blocks entering this cycle
  //--------------------------------------------------------------------------
  always_comb begin
    w_st_inc = '0;
    for (int k = 0; k < BB_COUNT; k++) begin
      if (bb_valid[k]) begin
        w_st_inc = w_st_inc + bb_st_count[k*COUNT_WIDTH +: COUNT_WIDTH];
      end
    end
  end

  // A store with nothing pending and nothing announced is an underflow
  assign w_underflow = w_store_en & (r_st_count == '0) & (w_st_inc == '0);

  // Pending-store counter and sticky underflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st_count  <= '0;
      r_underflow <= 1'b0;
    end else if (w_underflow) begin
      r_underflow <= 1'b1;
    end else begin
      r_st_count <= r_st_count + w_st_inc - {{(COUNT_WIDTH-1){1'b0}}, w_store_en};
    end
  end

  assign underflow_err = r_underflow;
  assign empty_valid   = (r_st_count == '0) & ~(|bb_valid);
  assign bb_ready      = '1;

endmodule
`default_nettype wire
